// File: rtl/strm_downsizer.sv
// strm_downsizer: splits each IN_WIDTH-bit input word into RATIO = IN_WIDTH/OUT_WIDTH
// chunks of OUT_WIDTH bits and emits them one per handshake on a valid/ready source.
// Intended to sit on the read side of a synchronous fifo.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   in_valid   input word valid (fifo rd side)
//   in_ready   input word ready; high in idle or on an accepted last chunk
//   in_data    input word
//   out_valid  output chunk valid (registered)
//   out_ready  output chunk ready
//   out_data   output chunk (selected from the hold register)
//   busy       high while a word is held and not fully emitted
//   chunk_idx  index of the chunk currently on out_data
module strm_downsizer #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 4,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int unsigned CW       = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy,
  output logic [CW-1:0]        chunk_idx
);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("strm_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  localparam logic [CW-1:0] LastIdx = CW'(RATIO - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                              state_q, state_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0]     hold_q, hold_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic                                last;
  logic [CW-1:0]                       sel;

  assign last = (cnt_q == LastIdx);

  // Chunk order: cnt counts emission order; sel maps it to the physical slice.
  assign sel = LSB_FIRST ? cnt_q : (LastIdx - cnt_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          hold_d  = in_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (out_ready) begin
          if (!last) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            // Reload on the last chunk so consecutive words leave no bubble.
            if (in_valid) begin
              hold_d = in_data;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // in_ready depends on out_ready only; this is the one combinational path.
  assign in_ready  = (state_q == StIdle) || (last && out_ready);
  assign out_valid = (state_q == StShift);
  assign busy      = (state_q == StShift);
  assign out_data  = hold_q[sel];
  assign chunk_idx = cnt_q;

endmodule

// File: tb/tb_strm_downsizer.sv
// Testbench for strm_downsizer: table-driven cycle vectors (LSB-first and MSB-first
// instances side by side) plus hand-written reset-mid-word and fifo-fed random
// backpressure sequences.
module tb_strm_downsizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [3:0]  out_data;
  logic [1:0]  chunk_idx;

  logic        m_in_ready, m_out_valid, m_busy;
  logic [3:0]  m_out_data;
  logic [1:0]  m_chunk_idx;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  strm_downsizer #(.IN_WIDTH(16), .OUT_WIDTH(4), .LSB_FIRST(1'b1)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .chunk_idx (chunk_idx)
  );

  strm_downsizer #(.IN_WIDTH(16), .OUT_WIDTH(4), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (m_in_ready),
    .in_data   (in_data),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_data  (m_out_data),
    .busy      (m_busy),
    .chunk_idx (m_chunk_idx)
  );

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        ov;     // expected out_valid and busy
    logic        chk_d;  // compare data only while a chunk is presented
    logic [3:0]  od;     // expected LSB-first chunk
    logic [3:0]  om;     // expected MSB-first chunk
    logic        irdy;
    logic [1:0]  idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [15:0] id, logic ordy, logic ov, logic chk_d,
                              logic [3:0] od, logic [3:0] om, logic irdy, logic [1:0] idx);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.ov = ov; v.chk_d = chk_d;
    v.od = od; v.om = om; v.irdy = irdy; v.idx = idx;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] fifo[$];
  logic [15:0] sent[$];
  logic [3:0]  el[4];
  logic [3:0]  em[4];

  initial begin
    // Single word 0xABCD
    vecs.push_back(mk(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hD, 4'hA, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hC, 4'hB, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hB, 4'hC, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hA, 4'hD, 1'b1, 2'd3));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0));
    // Back-to-back 0x1234, 0x5678
    vecs.push_back(mk(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0));
    vecs.push_back(mk(1'b1, 16'h5678, 1'b1, 1'b1, 1'b1, 4'h4, 4'h1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b1, 16'h5678, 1'b1, 1'b1, 1'b1, 4'h3, 4'h2, 1'b0, 2'd1));
    vecs.push_back(mk(1'b1, 16'h5678, 1'b1, 1'b1, 1'b1, 4'h2, 4'h3, 1'b0, 2'd2));
    vecs.push_back(mk(1'b1, 16'h5678, 1'b1, 1'b1, 1'b1, 4'h1, 4'h4, 1'b1, 2'd3));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h8, 4'h5, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h7, 4'h6, 1'b0, 2'd1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h6, 4'h7, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h5, 4'h8, 1'b1, 2'd3));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0));
    // Backpressure at chunk_idx 2, with a competing input word offered
    vecs.push_back(mk(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hD, 4'hA, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hC, 4'hB, 1'b0, 2'd1));
    vecs.push_back(mk(1'b1, 16'h9999, 1'b0, 1'b1, 1'b1, 4'hB, 4'hC, 1'b0, 2'd2));
    vecs.push_back(mk(1'b1, 16'h9999, 1'b0, 1'b1, 1'b1, 4'hB, 4'hC, 1'b0, 2'd2));
    vecs.push_back(mk(1'b1, 16'h9999, 1'b0, 1'b1, 1'b1, 4'hB, 4'hC, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hB, 4'hC, 1'b0, 2'd2));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'hA, 4'hD, 1'b1, 2'd3));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0));

    // Reset state
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check("rst in_ready", 16'(in_ready), 16'd1);
    check("rst out_valid", 16'(out_valid), 16'd0);
    check("rst busy", 16'(busy), 16'd0);
    check("rst chunk_idx", 16'(chunk_idx), 16'd0);
    check("rst out_data", 16'(out_data), 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d out_valid", i), 16'(out_valid), 16'(vecs[i].ov));
      check($sformatf("v%0d busy", i), 16'(busy), 16'(vecs[i].ov));
      check($sformatf("v%0d in_ready", i), 16'(in_ready), 16'(vecs[i].irdy));
      check($sformatf("v%0d chunk_idx", i), 16'(chunk_idx), 16'(vecs[i].idx));
      check($sformatf("v%0d msb in_ready", i), 16'(m_in_ready), 16'(vecs[i].irdy));
      if (vecs[i].chk_d) begin
        check($sformatf("v%0d out_data", i), 16'(out_data), 16'(vecs[i].od));
        check($sformatf("v%0d msb out_data", i), 16'(m_out_data), 16'(vecs[i].om));
      end
      step();
    end

    // Reset asserted mid-word, right after chunk C has been taken
    in_valid = 1'b1; in_data = 16'hABCD; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = '0;
    step();
    step();
    check("pre-reset out_data", 16'(out_data), 16'hB);
    rstn = 1'b0;
    #1;
    check("async rst out_valid", 16'(out_valid), 16'd0);
    check("async rst busy", 16'(busy), 16'd0);
    check("async rst in_ready", 16'(in_ready), 16'd1);
    check("async rst chunk_idx", 16'(chunk_idx), 16'd0);
    check("async rst out_data", 16'(out_data), 16'd0);
    check("async rst msb out_valid", 16'(m_out_valid), 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    in_valid = 1'b1; in_data = 16'h0F0F;
    step();
    in_valid = 1'b0; in_data = '0;
    el = '{4'hF, 4'h0, 4'hF, 4'h0};
    em = '{4'h0, 4'hF, 4'h0, 4'hF};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("post-rst chunk%0d", k), 16'(out_data), 16'(el[k]));
      check($sformatf("post-rst msb chunk%0d", k), 16'(m_out_data), 16'(em[k]));
      step();
    end
    check("post-rst idle", 16'(busy), 16'd0);

    // Fifo-fed stream with random out_ready, reassembled by a scoreboard
    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      fifo.push_back(w);
      sent.push_back(w);
    end
    begin
      int          got = 0;
      int          k = 0;
      int          cycles = 0;
      logic [15:0] acc = '0;
      logic [3:0]  prev_d = '0;
      logic        prev_stall = 1'b0;
      logic        do_in, do_out;
      while (got < 8 && cycles < 400) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = (fifo.size() > 0);
        in_data   = in_valid ? fifo[0] : 16'h0;
        #1;
        if (prev_stall) begin
          check("stall out_valid", 16'(out_valid), 16'd1);
          check("stall out_data", 16'(out_data), 16'(prev_d));
        end
        do_in  = in_valid && in_ready;
        do_out = out_valid && out_ready;
        if (do_out) begin
          acc[k*4 +: 4] = out_data;
          if (k == 3) begin
            check($sformatf("fifo word%0d", got), acc, sent[got]);
            got++;
            k = 0;
          end else begin
            k++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        step();
        if (do_in) void'(fifo.pop_front());
        cycles++;
      end
      check("fifo words received", 16'(got), 16'd8);
    end
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check("fifo empty", 16'(fifo.size()), 16'd0);
    check("end busy", 16'(busy), 16'd0);
    check("end in_ready", 16'(in_ready), 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
